// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and hazard controller for a 5-stage MIPS pipeline.
// - Keeps shadow copies of the destination and control fields for EX, MEM and
//   WB, so the datapath only supplies the decoded ID-stage fields.
// - Produces the operand-mux selects for the EX instruction:
//   00 = register file, 01 = writeback result, 1x = EX/MEM ALU result.
// - Detects load-use hazards. On a hazard it stalls the front end for one
//   cycle and inserts a bubble into EX.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source register addresses
//   id_uses_rs, id_uses_rt     ID instruction actually reads rs / rt
//   id_rd                      ID final destination address
//   id_regwrite, id_memread    ID writes a register / is a load
//   flush                      kill the instruction entering EX
//   hold                       freeze the whole pipeline
//   fwd_a_sel, fwd_b_sel       operand A (rs) / B (rt) mux selects for EX
//   stall                      disable PC and IF/ID writes
//   bubble                     load a NOP into ID/EX
//   stall_count                saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count
);

  logic            ex_valid;
  logic [RA_W-1:0] ex_rs;
  logic [RA_W-1:0] ex_rt;
  logic [RA_W-1:0] ex_rd;
  logic            ex_regwrite;
  logic            ex_memread;

  logic            mem_valid;
  logic [RA_W-1:0] mem_rd;
  logic            mem_regwrite;

  logic            wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic            wb_regwrite;

  logic            lu;

  // MEM (newer) has priority over WB; $0 is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic            src_valid,
    input logic [RA_W-1:0] src,
    input logic            m_valid,
    input logic            m_regwrite,
    input logic [RA_W-1:0] m_rd,
    input logic            w_valid,
    input logic            w_regwrite,
    input logic [RA_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src_valid) begin
      if (m_valid && m_regwrite && (m_rd != '0) && (m_rd == src))
        sel = 2'b10;
      else if (w_valid && w_regwrite && (w_rd != '0) && (w_rd == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  // Saturating increment for the stall statistics counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign fwd_a_sel = fwd_select(ex_valid, ex_rs, mem_valid, mem_regwrite, mem_rd,
                                wb_valid, wb_regwrite, wb_rd);
  assign fwd_b_sel = fwd_select(ex_valid, ex_rt, mem_valid, mem_regwrite, mem_rd,
                                wb_valid, wb_regwrite, wb_rd);

  // A load in EX whose destination is read by the ID instruction.
  assign lu = id_valid && ex_valid && ex_memread && ex_regwrite && (ex_rd != '0) &&
              ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // hold freezes everything, so no bubble may be loaded while it is high;
  // flush kills the ID instruction, which makes a stall on it pointless.
  assign stall  = hold | (lu & ~flush);
  assign bubble = ~hold & (flush | lu);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
      stall_count  <= '0;
    end else if (!hold) begin
      // MEM -> WB
      wb_valid     <= mem_valid;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      // EX -> MEM
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      // ID -> EX
      ex_valid     <= id_valid & ~bubble;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_regwrite  <= id_regwrite;
      ex_memread   <= id_memread;
      if (lu && !flush)
        stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;
  localparam int RA_W = 5;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic            id_uses_rs, id_uses_rt;
  logic            id_regwrite, id_memread;
  logic            flush, hold;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic            stall, bubble;
  logic [CW-1:0]   stall_count;

  int checks = 0;
  int errors = 0;

  fwd_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush), .hold(hold),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .bubble(bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                        input logic urt, input int rd, input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = RA_W'(rs);
    id_rt       = RA_W'(rt);
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_rd       = RA_W'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    // Reset state
    check("rst_fwd_a", fwd_a_sel, 2'b00);
    check("rst_fwd_b", fwd_b_sel, 2'b00);
    check("rst_stall", stall, 1'b0);
    check("rst_bubble", bubble, 1'b0);
    check("rst_count", stall_count, 0);
    hold = 1'b1;
    #1;
    check("rst_stall_eq_hold", stall, 1'b1);
    check("rst_bubble_hold", bubble, 1'b0);
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Forward from MEM: add $3 ; sub $4,$3,$5
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    check("add_no_stall", stall, 1'b0);
    tick();
    set_id(1, 3, 5, 1, 1, 4, 1, 0);
    check("sub_no_stall", stall, 1'b0);
    tick();
    check("mem_fwd_a", fwd_a_sel, 2'b10);
    check("mem_fwd_b", fwd_b_sel, 2'b00);
    set_id(0, 3, 3, 1, 1, 0, 0, 0);
    tick();
    check("invalid_ex_a", fwd_a_sel, 2'b00);
    check("invalid_ex_b", fwd_b_sel, 2'b00);

    // Forward from WB: add $3 ; nop ; or $6,$7,$3
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 7, 3, 1, 1, 6, 1, 0);
    tick();
    check("wb_fwd_a", fwd_a_sel, 2'b00);
    check("wb_fwd_b", fwd_b_sel, 2'b01);

    // Priority: add $3 ; add $3 ; and $8,$3,$3
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    set_id(1, 3, 3, 1, 1, 8, 1, 0);
    tick();
    check("prio_fwd_a", fwd_a_sel, 2'b10);
    check("prio_fwd_b", fwd_b_sel, 2'b10);

    // Load-use: lw $2 ; add $9,$2,$1
    set_id(1, 29, 0, 1, 0, 2, 1, 1);
    tick();
    set_id(1, 2, 1, 1, 1, 9, 1, 0);
    check("lu_stall", stall, 1'b1);
    check("lu_bubble", bubble, 1'b1);
    check("lu_count0", stall_count, 0);
    tick();
    check("lu_stall_gone", stall, 1'b0);
    check("lu_bubble_gone", bubble, 1'b0);
    check("lu_count1", stall_count, 1);
    check("lu_bubble_ex_a", fwd_a_sel, 2'b00);
    tick();
    check("lu_wb_fwd_a", fwd_a_sel, 2'b01);
    check("lu_wb_fwd_b", fwd_b_sel, 2'b00);

    // $0 destination: lw $0 ; add $10,$0,$0
    set_id(1, 29, 0, 1, 0, 0, 1, 1);
    tick();
    set_id(1, 0, 0, 1, 1, 10, 1, 0);
    check("r0_stall", stall, 1'b0);
    check("r0_bubble", bubble, 1'b0);
    tick();
    check("r0_fwd_a", fwd_a_sel, 2'b00);
    check("r0_fwd_b", fwd_b_sel, 2'b00);

    // Unused rt matching the load: lw $5 ; addi $11,$1,imm (rt=5 unused)
    set_id(1, 29, 0, 1, 0, 5, 1, 1);
    tick();
    set_id(1, 1, 5, 1, 0, 11, 1, 0);
    check("unused_rt_stall", stall, 1'b0);
    check("unused_rt_bubble", bubble, 1'b0);
    tick();
    check("unused_rt_count", stall_count, 1);

    // Flush overrides load-use
    set_id(1, 29, 0, 1, 0, 6, 1, 1);
    tick();
    flush = 1'b1;
    set_id(1, 6, 1, 1, 1, 7, 1, 0);
    check("flush_stall", stall, 1'b0);
    check("flush_bubble", bubble, 1'b1);
    tick();
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    check("flush_count", stall_count, 1);
    check("flush_ex_a", fwd_a_sel, 2'b00);
    check("flush_ex_b", fwd_b_sel, 2'b00);
    check("flush_after_stall", stall, 1'b0);

    // Hold during pending forward and pending load-use
    set_id(1, 1, 2, 1, 1, 13, 1, 0);
    tick();
    set_id(1, 13, 0, 1, 0, 12, 1, 1);
    check("pre_hold_stall", stall, 1'b0);
    tick();
    hold = 1'b1;
    set_id(1, 12, 1, 1, 1, 14, 1, 0);
    check("hold_fwd_a", fwd_a_sel, 2'b10);
    check("hold_fwd_b", fwd_b_sel, 2'b00);
    check("hold_stall", stall, 1'b1);
    check("hold_bubble", bubble, 1'b0);
    check("hold_count", stall_count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_fwd_a", fwd_a_sel, 2'b10);
      check("held_stall", stall, 1'b1);
      check("held_bubble", bubble, 1'b0);
      check("held_count", stall_count, 1);
    end
    hold = 1'b0;
    #1;
    check("unhold_stall", stall, 1'b1);
    check("unhold_bubble", bubble, 1'b1);
    tick();
    check("unhold_count", stall_count, 2);
    check("unhold_stall_gone", stall, 1'b0);
    tick();
    check("unhold_wb_fwd_a", fwd_a_sel, 2'b01);
    check("unhold_wb_fwd_b", fwd_b_sel, 2'b00);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fwd_a", fwd_a_sel, 2'b00);
    check("arst_stall", stall, 1'b0);
    check("arst_bubble", bubble, 1'b0);
    check("arst_count", stall_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1, 12, 13, 1, 1, 14, 1, 0);
    check("post_rst_stall", stall, 1'b0);
    tick();
    check("post_rst_fwd_a", fwd_a_sel, 2'b00);
    check("post_rst_fwd_b", fwd_b_sel, 2'b00);

    // Counter saturation: eight load-use stalls into a 3-bit counter
    for (int i = 0; i < 8; i++) begin
      set_id(1, 29, 0, 1, 0, 2, 1, 1);
      tick();
      set_id(1, 2, 1, 1, 1, 9, 1, 0);
      check("sat_stall", stall, 1'b1);
      tick();
      check("sat_count", stall_count, (i + 1 > 7) ? 7 : i + 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage MIPS pipeline. It produces the 2-bit select codes for the two 32-bit 3:1 ALU-operand muxes: 00 = register-file value, 01 = writeback result, 1x = EX/MEM ALU result. It detects load-use hazards and stalls the front end for exactly one cycle while inserting a bubble into EX. It keeps its own shadow copy of destination/control fields for the EX, MEM and WB stages, so the datapath only supplies decoded ID-stage fields.

## Interface
Parameters:
- RA_W, 5, register address width
- CNT_W, 16, width of the stall statistics counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  RA_W  source register addresses of the ID instruction
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_rd  in  RA_W  final destination address (after RegDst mux)
- id_regwrite, id_memread  in  1  ID instruction writes a register / is a load
- flush  in  1  branch/jump resolved taken; kill the instruction entering EX
- hold  in  1  external memory wait; freeze the whole pipeline
- fwd_a_sel, fwd_b_sel  out  2  mux selects for ALU operands A (rs) and B (rt) of the EX instruction
- stall  out  1  disable PC and IF/ID register writes this cycle
- bubble  out  1  load a NOP into ID/EX this cycle
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Shadow pipeline registers:
  - EX: ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread
  - MEM: mem_valid, mem_rd, mem_regwrite
  - WB: wb_valid, wb_rd, wb_regwrite
- Each rising edge with hold=0 and rst_n=1:
  - WB <= MEM
  - MEM <= EX
  - EX <= ID fields, with ex_valid = id_valid & ~bubble
- hold=1: all shadow registers and stall_count keep their value.
- Forwarding, combinational from shadow state, computed per operand (A uses ex_rs, B uses ex_rt):
  - 2'b10 when mem_valid & mem_regwrite & mem_rd!=0 & mem_rd==src
  - else 2'b01 when wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==src
  - else 2'b00
  - MEM has priority over WB.
  - ex_valid=0 forces 2'b00.
- Load-use hazard lu:
  - Condition: id_valid & ex_valid & ex_memread & ex_regwrite & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - After one stall the load reaches WB and the consumer receives the load data via select 01. There is no second stall.
- Output equations:
  - stall = hold | (lu & ~flush)
  - bubble = ~hold & (flush | lu)
- flush priority: flush overrides lu (the ID instruction is killed anyway).
- hold priority: hold overrides flush. The flush source keeps flush asserted until hold drops.
- stall_count increments on each edge where lu & ~flush & ~hold, and saturates at all-ones.

## Timing
- Reset (rst_n=0, immediate, asynchronous):
  - all valid bits 0, all address fields 0, stall_count 0
  - therefore fwd_a_sel = fwd_b_sel = 00, stall = hold, bubble = 0
- Forward selects are valid throughout the cycle the consumer occupies EX. They depend only on registers, so there is zero combinational path from ID inputs.
- stall and bubble are combinational from ID inputs plus EX shadow, in the same cycle the hazard is visible in ID.
- Load-use costs exactly 1 stall cycle. For back-to-back loads feeding each other, each pair costs 1.
- Reset released mid-operation: the first instruction entering ID is processed normally. No stale forwarding is possible, because all valid bits are 0.
- Writes to $0 are never forwarded and never cause a stall.
- Simultaneous MEM and WB match on the same register: MEM (newer) wins.

## Test plan
- **Forward from MEM:** `add $3` followed by `sub $4,$3,$5`. With the sub in EX → fwd_a_sel=10, fwd_b_sel=00.
- **Forward from WB and priority:**
  - `add $3`, nop, `or $6,$7,$3` → fwd_b_sel=01.
  - `add $3`, `add $3`, `and $8,$3,$3` → both selects 10.
- **Load-use:** `lw $2` in EX, `add $9,$2,$1` in ID → stall=1 and bubble=1 for one cycle. Next cycle stall=0 and the add enters EX with fwd_a_sel=01. stall_count goes 0→1.
- **$0 and unused operands:**
  - `lw $0` followed by a consumer of $0 → no stall, selects 00.
  - A consumer with id_uses_rt=0 whose rt matches the load → no stall.
- **Flush vs load-use:** lu condition true with flush=1 → stall=0, bubble=1, stall_count unchanged. Next cycle ex_valid=0 and selects read 00.
- **Hold and reset:**
  - hold=1 for 3 cycles during a pending forward → selects and stall_count frozen, bubble=0, stall=1.
  - Assert rst_n=0 mid-stream → outputs go to 00/0 without waiting for a clock edge. After release, the first instruction is not forwarded.
